writeback_arbiter: RTL

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/core_pkg.sv | 19 +
 rtl/writeback_arbiter_if.sv | 50 +++++
 rtl/wb_fifo.sv | 64 ++++++
 rtl/writeback_arbiter.sv | 74 +++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions used by the writeback path: default queue depth,
// the queued writeback entry layout and a small entry builder.
package core_pkg;

  localparam int WB_DEPTH = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } wb_entry_t;

  function automatic wb_entry_t make_wb_entry(input logic [4:0] rd, input logic [63:0] data);
    wb_entry_t e;
    e.rd   = rd;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Bundle of the ALU and load result channels, the register-file write port
// and the queue status outputs of the writeback arbiter.
//
// Handshake: a channel transfers on a rising clk edge where valid and ready
// are both high. The producer holds rd/data stable while valid is high;
// ready never depends on the same channel's valid, so there is no
// combinational loop between producer and arbiter.
interface writeback_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          alu_valid;
  logic [4:0]    alu_rd;
  logic [63:0]   alu_data;
  logic          alu_ready;

  logic          ld_valid;
  logic [4:0]    ld_rd;
  logic [63:0]   ld_data;
  logic          ld_ready;

  logic [4:0]    rf_rd;
  logic [63:0]   rf_writedata;
  logic          rf_reg_write;

  logic [31:0]   pend_mask;
  logic [CW-1:0] count;

  // Producer side (execution units / testbench)
  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output ld_valid, ld_rd, ld_data,
    input  ld_ready,
    input  rf_rd, rf_writedata, rf_reg_write,
    input  pend_mask, count
  );

  // Arbiter side
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  ld_valid, ld_rd, ld_data,
    output ld_ready,
    output rf_rd, rf_writedata, rf_reg_write,
    output pend_mask, count
  );

endinterface

// File: rtl/wb_fifo.sv
// Dual-push, single-pop circular queue of writeback entries. Push port 0 is
// written ahead of push port 1 when both fire on the same edge. Full/empty
// are told apart by the occupancy count, never by pointer equality.
module wb_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push0,
  input  wb_entry_t             entry0,
  input  logic                  push1,
  input  wb_entry_t             entry1,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic [AW-1:0]         rd_ptr,
  output logic [CW-1:0]         count,
  output wb_entry_t [DEPTH-1:0] entries
);

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [AW-1:0]         second_slot;

  // Next-state: write up to two entries in order, advance pointers mod DEPTH
  always_comb begin
    mem_d       = mem_q;
    second_slot = wr_ptr_q + AW'(push0);
    if (push0) mem_d[wr_ptr_q]    = entry0;
    if (push1) mem_d[second_slot] = entry1;
    wr_ptr_d = wr_ptr_q + AW'(push0) + AW'(push1);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push0) + CW'(push1) - CW'(pop);
  end

  // Pointer and occupancy registers; reset empties the queue
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: slots are only read while counted as occupied
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head    = mem_q[rd_ptr_q];
  assign rd_ptr  = rd_ptr_q;
  assign count   = count_q;
  assign entries = mem_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and load results into a single register-file write port via a
// small queue. Loads get priority for the last free slot; writes to x0 are
// acknowledged but dropped. pend_mask flags registers with queued writes.
module writeback_arbiter
  import core_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input logic                 clk,
  input logic                 reset,
  writeback_arbiter_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = CW + 1;

  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] entries;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  pop;
  logic [FW-1:0]         free;
  logic                  ld_ready, alu_ready;
  logic                  ld_push, alu_push;
  logic [AW-1:0]         slot_off;
  logic [31:0]           pend_mask_c;

  // Slots usable this edge count the one freed by the head pop
  always_comb begin
    pop       = (count != '0);
    free      = FW'(DEPTH) - FW'(count) + FW'(pop);
    ld_ready  = !reset && (free >= FW'(1));
    alu_ready = !reset && ((free >= FW'(2)) || ((free >= FW'(1)) && !bus.ld_valid));
    ld_push   = bus.ld_valid  && ld_ready  && (bus.ld_rd  != 5'd0);
    alu_push  = bus.alu_valid && alu_ready && (bus.alu_rd != 5'd0);
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push0   (ld_push),
    .entry0  (make_wb_entry(bus.ld_rd, bus.ld_data)),
    .push1   (alu_push),
    .entry1  (make_wb_entry(bus.alu_rd, bus.alu_data)),
    .pop     (pop),
    .head    (head),
    .rd_ptr  (rd_ptr),
    .count   (count),
    .entries (entries)
  );

  // One-hot OR of destination registers over the occupied window
  always_comb begin
    pend_mask_c = '0;
    slot_off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = AW'(i) - rd_ptr;
      if (CW'(slot_off) < count) pend_mask_c[entries[i].rd] = 1'b1;
    end
    pend_mask_c[0] = 1'b0;
  end

  assign bus.alu_ready    = alu_ready;
  assign bus.ld_ready     = ld_ready;
  assign bus.rf_reg_write = pop;
  assign bus.rf_rd        = pop ? head.rd   : 5'd0;
  assign bus.rf_writedata = pop ? head.data : 64'd0;
  assign bus.pend_mask    = pend_mask_c;
  assign bus.count        = count;

endmodule
